// File: rtl/instr_dispatch.sv
// instr_dispatch: instruction FIFO feeding a three-state dispatcher that issues
// LOAD / STORE / GEMM requests over req/ack handshakes, with RAW/WAW hazard
// protection against outstanding LOAD and GEMM results.
//
// Ports:
//   CLK, nRST                      clock, asynchronous active-low reset
//   instrFIFO_WEN/_wdata           push strobe and 40-bit instruction
//   instrFIFO_full/_empty          registered FIFO status
//   load_req/ack, load_matrix/addr         LOAD issue handshake + payload
//   store_req/ack, store_matrix/addr       STORE issue handshake + payload
//   gemm_req/ack, gemm_new_weight, gemm_rd/rs1/rs2/rs3  GEMM issue
//   load_done/_id, gemm_done/_id   completion reports
//   idle                           FIFO empty, FSM idle, nothing outstanding
//
// Build option: define DISPATCH_SCOREBOARD_EN for a per-matrix busy vector;
// otherwise a 7-bit outstanding counter gates STORE and GEMM.
module instr_dispatch #(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        instrFIFO_WEN,
  input  logic [39:0] instrFIFO_wdata,
  output logic        instrFIFO_full,
  output logic        instrFIFO_empty,
  output logic        load_req,
  input  logic        load_ack,
  output logic [5:0]  load_matrix,
  output logic [31:0] load_addr,
  output logic        store_req,
  input  logic        store_ack,
  output logic [5:0]  store_matrix,
  output logic [31:0] store_addr,
  output logic        gemm_req,
  input  logic        gemm_ack,
  output logic        gemm_new_weight,
  output logic [5:0]  gemm_rd,
  output logic [5:0]  gemm_rs1,
  output logic [5:0]  gemm_rs2,
  output logic [5:0]  gemm_rs3,
  input  logic        load_done,
  input  logic [5:0]  load_done_id,
  input  logic        gemm_done,
  input  logic [5:0]  gemm_done_id,
  output logic        idle
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_STORE = 2'd2;
  localparam logic [1:0] OP_GEMM  = 2'd3;

  typedef struct packed {
    logic [1:0]  op;
    logic [5:0]  field;
    logic [31:0] sel;
  } instr_t;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CHECK = 2'd1, S_ISSUE = 2'd2} state_e;

  state_e        state_q, state_d;
  instr_t        mem_q [FIFO_DEPTH];
  instr_t        instr_q, head_c;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full_q, full_d, empty_q, empty_d, idle_q, idle_d;
  logic          push_c, pop_c, stall_c, ack_hit_c, clear_c;

  logic          load_req_q, load_req_d, store_req_q, store_req_d, gemm_req_q, gemm_req_d;
  logic [5:0]    load_matrix_q, load_matrix_d, store_matrix_q, store_matrix_d;
  logic [31:0]   load_addr_q, load_addr_d, store_addr_q, store_addr_d;
  logic          gemm_nw_q, gemm_nw_d;
  logic [5:0]    gemm_rd_q, gemm_rd_d, gemm_rs1_q, gemm_rs1_d;
  logic [5:0]    gemm_rs2_q, gemm_rs2_d, gemm_rs3_q, gemm_rs3_d;

  // FIFO bookkeeping; a pop frees a slot for a same-cycle push even when full
  always_comb begin
    head_c  = mem_q[rptr_q];
    pop_c   = (state_q == S_IDLE) && !empty_q;
    push_c  = instrFIFO_WEN && (!full_q || pop_c);
    wptr_d  = push_c ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop_c  ? rptr_q + AW'(1) : rptr_q;
    cnt_d   = cnt_q + CW'(push_c) - CW'(pop_c);
    full_d  = (cnt_d == CW'(FIFO_DEPTH));
    empty_d = (cnt_d == '0);
  end

  always_ff @(posedge CLK) begin
    if (push_c) mem_q[wptr_q] <= instr_t'(instrFIFO_wdata);
  end

  assign ack_hit_c = (load_req_q && load_ack) || (store_req_q && store_ack) ||
                     (gemm_req_q && gemm_ack);

`ifdef DISPATCH_SCOREBOARD_EN
  // Per-matrix busy vector; a set in the same cycle as a clear wins
  logic [63:0] busy_q, busy_d, set_c, clr_c;

  always_comb begin
    set_c = '0;
    clr_c = '0;
    if (load_req_q && load_ack) set_c[load_matrix_q] = 1'b1;
    if (gemm_req_q && gemm_ack) set_c[gemm_rd_q]     = 1'b1;
    if (load_done) clr_c[load_done_id] = 1'b1;
    if (gemm_done) clr_c[gemm_done_id] = 1'b1;
    busy_d = (busy_q & ~clr_c) | set_c;
  end

  always_comb begin
    stall_c = 1'b0;
    case (instr_q.op)
      OP_LOAD, OP_STORE: stall_c = busy_q[instr_q.field];
      OP_GEMM: stall_c = busy_q[instr_q.sel[23:18]] | busy_q[instr_q.sel[17:12]] |
                         busy_q[instr_q.sel[11:6]]  | busy_q[instr_q.sel[5:0]];
      default: stall_c = 1'b0;
    endcase
  end

  assign clear_c = (busy_d == '0);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) busy_q <= '0;
    else       busy_q <= busy_d;
  end
`else
  // Outstanding LOAD/GEMM counter; never underflows on a stray done
  localparam int unsigned OW  = 7;
  localparam int unsigned OW1 = OW + 1;
  logic [OW-1:0] out_q, out_d;
  logic [OW1-1:0] sum_c, dec_c, diff_c;
  logic          inc_c;
  logic          unused_done_ids;

  assign unused_done_ids = ^{load_done_id, gemm_done_id};

  always_comb begin
    inc_c  = (load_req_q && load_ack) || (gemm_req_q && gemm_ack);
    sum_c  = {1'b0, out_q} + OW1'(inc_c);
    dec_c  = OW1'(load_done) + OW1'(gemm_done);
    diff_c = sum_c - dec_c;
    if (sum_c < dec_c)   out_d = '0;
    else if (diff_c[OW]) out_d = '1;
    else                 out_d = diff_c[OW-1:0];
    stall_c = ((instr_q.op == OP_GEMM) || (instr_q.op == OP_STORE)) && (out_q != '0);
  end

  assign clear_c = (out_d == '0);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) out_q <= '0;
    else       out_q <= out_d;
  end
`endif

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state; NOPs are discarded straight out of IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!empty_q && (head_c.op != OP_NOP)) state_d = S_CHECK;
      S_CHECK: begin
        if (instr_q.op == OP_NOP) state_d = S_IDLE;
        else if (!stall_c)        state_d = S_ISSUE;
      end
      S_ISSUE: if (ack_hit_c) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request/payload next values; payload is held until the next issue
  always_comb begin
    load_req_d     = load_req_q;
    store_req_d    = store_req_q;
    gemm_req_d     = gemm_req_q;
    load_matrix_d  = load_matrix_q;
    load_addr_d    = load_addr_q;
    store_matrix_d = store_matrix_q;
    store_addr_d   = store_addr_q;
    gemm_nw_d      = gemm_nw_q;
    gemm_rd_d      = gemm_rd_q;
    gemm_rs1_d     = gemm_rs1_q;
    gemm_rs2_d     = gemm_rs2_q;
    gemm_rs3_d     = gemm_rs3_q;
    if ((state_q == S_ISSUE) && ack_hit_c) begin
      load_req_d  = 1'b0;
      store_req_d = 1'b0;
      gemm_req_d  = 1'b0;
    end
    if ((state_q == S_CHECK) && !stall_c) begin
      case (instr_q.op)
        OP_LOAD: begin
          load_req_d    = 1'b1;
          load_matrix_d = instr_q.field;
          load_addr_d   = instr_q.sel;
        end
        OP_STORE: begin
          store_req_d    = 1'b1;
          store_matrix_d = instr_q.field;
          store_addr_d   = instr_q.sel;
        end
        OP_GEMM: begin
          gemm_req_d = 1'b1;
          gemm_nw_d  = instr_q.field[5];
          gemm_rd_d  = instr_q.sel[23:18];
          gemm_rs1_d = instr_q.sel[17:12];
          gemm_rs2_d = instr_q.sel[11:6];
          gemm_rs3_d = instr_q.sel[5:0];
        end
        default: ;
      endcase
    end
    idle_d = empty_d && (state_d == S_IDLE) && clear_c;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wptr_q <= '0; rptr_q <= '0; cnt_q <= '0;
      full_q <= 1'b0; empty_q <= 1'b1; idle_q <= 1'b1;
      instr_q <= '0;
      load_req_q <= 1'b0; store_req_q <= 1'b0; gemm_req_q <= 1'b0;
      load_matrix_q <= '0; load_addr_q <= '0;
      store_matrix_q <= '0; store_addr_q <= '0;
      gemm_nw_q <= 1'b0; gemm_rd_q <= '0; gemm_rs1_q <= '0;
      gemm_rs2_q <= '0; gemm_rs3_q <= '0;
    end else begin
      wptr_q <= wptr_d; rptr_q <= rptr_d; cnt_q <= cnt_d;
      full_q <= full_d; empty_q <= empty_d; idle_q <= idle_d;
      if (pop_c) instr_q <= head_c;
      load_req_q <= load_req_d; store_req_q <= store_req_d; gemm_req_q <= gemm_req_d;
      load_matrix_q <= load_matrix_d; load_addr_q <= load_addr_d;
      store_matrix_q <= store_matrix_d; store_addr_q <= store_addr_d;
      gemm_nw_q <= gemm_nw_d; gemm_rd_q <= gemm_rd_d; gemm_rs1_q <= gemm_rs1_d;
      gemm_rs2_q <= gemm_rs2_d; gemm_rs3_q <= gemm_rs3_d;
    end
  end

  assign instrFIFO_full  = full_q;
  assign instrFIFO_empty = empty_q;
  assign idle            = idle_q;
  assign load_req        = load_req_q;
  assign load_matrix     = load_matrix_q;
  assign load_addr       = load_addr_q;
  assign store_req       = store_req_q;
  assign store_matrix    = store_matrix_q;
  assign store_addr      = store_addr_q;
  assign gemm_req        = gemm_req_q;
  assign gemm_new_weight = gemm_nw_q;
  assign gemm_rd         = gemm_rd_q;
  assign gemm_rs1        = gemm_rs1_q;
  assign gemm_rs2        = gemm_rs2_q;
  assign gemm_rs3        = gemm_rs3_q;

endmodule

// File: tb/tb_instr_dispatch.sv
// Directed bench for instr_dispatch: a vector table of single instructions
// plus hand-written sequences for FIFO full, hazards and reset mid-issue.
module tb_instr_dispatch;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        instrFIFO_WEN;
  logic [39:0] instrFIFO_wdata;
  logic        instrFIFO_full, instrFIFO_empty;
  logic        load_req, load_ack, store_req, store_ack, gemm_req, gemm_ack;
  logic [5:0]  load_matrix, store_matrix;
  logic [31:0] load_addr, store_addr;
  logic        gemm_new_weight;
  logic [5:0]  gemm_rd, gemm_rs1, gemm_rs2, gemm_rs3;
  logic        load_done, gemm_done;
  logic [5:0]  load_done_id, gemm_done_id;
  logic        idle;

  instr_dispatch #(.FIFO_DEPTH(8)) dut (
    .CLK(CLK), .nRST(nRST),
    .instrFIFO_WEN(instrFIFO_WEN), .instrFIFO_wdata(instrFIFO_wdata),
    .instrFIFO_full(instrFIFO_full), .instrFIFO_empty(instrFIFO_empty),
    .load_req(load_req), .load_ack(load_ack),
    .load_matrix(load_matrix), .load_addr(load_addr),
    .store_req(store_req), .store_ack(store_ack),
    .store_matrix(store_matrix), .store_addr(store_addr),
    .gemm_req(gemm_req), .gemm_ack(gemm_ack), .gemm_new_weight(gemm_new_weight),
    .gemm_rd(gemm_rd), .gemm_rs1(gemm_rs1), .gemm_rs2(gemm_rs2), .gemm_rs3(gemm_rs3),
    .load_done(load_done), .load_done_id(load_done_id),
    .gemm_done(gemm_done), .gemm_done_id(gemm_done_id),
    .idle(idle)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [39:0] instr;
    int          ack_dly;
    logic [1:0]  kind;     // 0 none, 1 load, 2 store, 3 gemm
    logic [63:0] payload;  // load/store {matrix,addr}; gemm {nw,rd,rs1,rs2,rs3}
  } vec_t;

  vec_t vec [6];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [39:0] d);
    instrFIFO_WEN   = 1'b1;
    instrFIFO_wdata = d;
    step();
    instrFIFO_WEN   = 1'b0;
  endtask

  task automatic wait_req(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (load_req || store_req || gemm_req) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  function automatic logic [2:0] reqs();
    return {load_req, store_req, gemm_req};
  endfunction

  function automatic logic [2:0] exp_reqs(input logic [1:0] kind);
    case (kind)
      2'd1:    return 3'b100;
      2'd2:    return 3'b010;
      2'd3:    return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [63:0] act_payload(input logic [1:0] kind);
    case (kind)
      2'd1:    return 64'({load_matrix, load_addr});
      2'd2:    return 64'({store_matrix, store_addr});
      2'd3:    return 64'({gemm_new_weight, gemm_rd, gemm_rs1, gemm_rs2, gemm_rs3});
      default: return 64'(0);
    endcase
  endfunction

  // LOAD then dependent GEMM: GEMM waits for the load completion
  task automatic gemm_after_load(input logic [23:0] gsel, input string tag);
    bit   ok;
    logic seen;
    push({2'd1, 6'h15, 32'h0000_0040});
    wait_req(10, ok);
    chk({tag, "_load_timeout"}, 64'(ok), 64'(1));
    load_ack = 1'b1; step(); load_ack = 1'b0;
    push({2'd3, 6'h00, 8'h00, gsel});
    seen = 1'b0;
    repeat (6) begin step(); seen = seen | gemm_req; end
    chk({tag, "_stall"}, 64'(seen), 64'(0));
    load_done = 1'b1; load_done_id = 6'h15; step(); load_done = 1'b0;
    chk({tag, "_same_cycle"}, 64'(gemm_req), 64'(0));
    step();
    chk({tag, "_rise"}, 64'(gemm_req), 64'(1));
    chk({tag, "_ids"}, 64'({gemm_rd, gemm_rs1, gemm_rs2, gemm_rs3}), 64'(gsel));
    gemm_ack = 1'b1; step(); gemm_ack = 1'b0;
    gemm_done = 1'b1; gemm_done_id = gsel[23:18]; step(); gemm_done = 1'b0;
    chk({tag, "_idle"}, 64'(idle), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit         ok;
    logic       seen;
    logic [39:0] ins;
    logic [31:0] ea;

    vec[0] = '{{2'd1, 6'h25, 32'h0000_0004}, 2, 2'd1, 64'({6'h25, 32'h0000_0004})};
    vec[1] = '{{2'd2, 6'h0A, 32'hDEAD_BEEF}, 0, 2'd2, 64'({6'h0A, 32'hDEAD_BEEF})};
    vec[2] = '{{2'd3, 6'h20, 8'hFF, 6'h35, 6'h15, 6'h25, 6'h05}, 1, 2'd3,
               64'({1'b1, 6'h35, 6'h15, 6'h25, 6'h05})};
    vec[3] = '{{2'd3, 6'h1F, 8'h00, 6'h3F, 6'h00, 6'h2A, 6'h11}, 1, 2'd3,
               64'({1'b0, 6'h3F, 6'h00, 6'h2A, 6'h11})};
    vec[4] = '{{2'd1, 6'h3F, 32'hFFFF_FFFC}, 3, 2'd1, 64'({6'h3F, 32'hFFFF_FFFC})};
    vec[5] = '{{2'd0, 6'h3F, 32'h1234_5678}, 0, 2'd0, 64'(0)};

    nRST = 1'b1; instrFIFO_WEN = 1'b0; instrFIFO_wdata = '0;
    load_ack = 1'b0; store_ack = 1'b0; gemm_ack = 1'b0;
    load_done = 1'b0; gemm_done = 1'b0; load_done_id = '0; gemm_done_id = '0;
    #2 nRST = 1'b0;
    step(); step();
    chk("rst_empty", 64'(instrFIFO_empty), 64'(1));
    chk("rst_full", 64'(instrFIFO_full), 64'(0));
    chk("rst_idle", 64'(idle), 64'(1));
    chk("rst_reqs", 64'(reqs()), 64'(0));
    chk("rst_payload", 64'({load_matrix, load_addr, store_matrix, gemm_rd}), 64'(0));
    nRST = 1'b1;
    step();

    // Single-instruction vectors
    for (int i = 0; i < 6; i++) begin
      ins = vec[i].instr;
      push(ins);
      chk($sformatf("v%0d_nonempty", i), 64'(instrFIFO_empty), 64'(0));
      step();
      chk($sformatf("v%0d_early", i), 64'(reqs()), 64'(0));
      step();
      chk($sformatf("v%0d_req", i), 64'(reqs()), 64'(exp_reqs(vec[i].kind)));
      if (vec[i].kind == 2'd0) begin
        repeat (3) step();
        chk($sformatf("v%0d_noreq", i), 64'(reqs()), 64'(0));
        chk($sformatf("v%0d_idle", i), 64'({instrFIFO_empty, idle}), 64'(3));
      end else begin
        chk($sformatf("v%0d_payload", i), act_payload(vec[i].kind), vec[i].payload);
        for (int d = 0; d < vec[i].ack_dly; d++) step();
        chk($sformatf("v%0d_hold", i), 64'({reqs(), act_payload(vec[i].kind)}),
            64'({exp_reqs(vec[i].kind), vec[i].payload}));
        case (vec[i].kind)
          2'd1:    load_ack  = 1'b1;
          2'd2:    store_ack = 1'b1;
          default: gemm_ack  = 1'b1;
        endcase
        step();
        load_ack = 1'b0; store_ack = 1'b0; gemm_ack = 1'b0;
        chk($sformatf("v%0d_drop", i), 64'(reqs()), 64'(0));
        if (vec[i].kind == 2'd2) begin
          chk($sformatf("v%0d_idle", i), 64'(idle), 64'(1));
        end else begin
          chk($sformatf("v%0d_busy", i), 64'(idle), 64'(0));
          if (vec[i].kind == 2'd1) begin
            load_done = 1'b1; load_done_id = ins[37:32];
          end else begin
            gemm_done = 1'b1; gemm_done_id = ins[23:18];
          end
          step();
          load_done = 1'b0; gemm_done = 1'b0;
          chk($sformatf("v%0d_idle", i), 64'(idle), 64'(1));
        end
      end
    end

    // FIFO full: block pops with an unacked LOAD, overfill, then drain in order
    push({2'd1, 6'h01, 32'h0000_AAAA});
    wait_req(10, ok);
    chk("full_block_timeout", 64'(ok), 64'(1));
    for (int k = 0; k < 8; k++) begin
      push({2'd1, 6'(8 + k), 32'(32'h100 + k)});
      if (k == 6) chk("full_at7", 64'(instrFIFO_full), 64'(0));
    end
    chk("full_at8", 64'({instrFIFO_full, instrFIFO_empty}), 64'(2'b10));
    push({2'd1, 6'h3E, 32'h0000_01FF});
    chk("full_drop9", 64'(instrFIFO_full), 64'(1));
    load_ack = 1'b1; step(); load_ack = 1'b0;
    push({2'd1, 6'h30, 32'h0000_01AA});
    chk("full_pushpop", 64'(instrFIFO_full), 64'(1));
    for (int k = 0; k < 9; k++) begin
      wait_req(10, ok);
      chk($sformatf("drain%0d_timeout", k), 64'(ok), 64'(1));
      ea = (k < 8) ? 32'(32'h100 + k) : 32'h0000_01AA;
      chk($sformatf("drain%0d_addr", k), 64'({load_req, load_addr}), 64'({1'b1, ea}));
      load_ack = 1'b1; step(); load_ack = 1'b0;
    end
    seen = 1'b0;
    repeat (6) begin step(); seen = seen | load_req | store_req | gemm_req; end
    chk("drain_extra", 64'(seen), 64'(0));
    chk("drain_empty", 64'(instrFIFO_empty), 64'(1));
    load_done = 1'b1;
    for (int k = 0; k < 10; k++) begin
      load_done_id = (k == 0) ? 6'h01 : ((k == 9) ? 6'h30 : 6'(7 + k));
      step();
    end
    load_done = 1'b0;
    chk("drain_idle", 64'(idle), 64'(1));

    // Hazards: dependent GEMM, and GEMM with unrelated IDs under the counter
    gemm_after_load({6'h35, 6'h15, 6'h25, 6'h05}, "haz_dep");
`ifndef DISPATCH_SCOREBOARD_EN
    gemm_after_load({6'h36, 6'h01, 6'h02, 6'h03}, "haz_cnt");
`endif

    // STORE after GEMM writing the same matrix
    push({2'd3, 6'h00, 8'h00, 6'h35, 6'h01, 6'h02, 6'h03});
    wait_req(10, ok);
    chk("st_gemm_timeout", 64'(ok), 64'(1));
    gemm_ack = 1'b1; step(); gemm_ack = 1'b0;
    push({2'd2, 6'h35, 32'd100});
    seen = 1'b0;
    repeat (6) begin step(); seen = seen | store_req; end
    chk("st_stall", 64'(seen), 64'(0));
    gemm_done = 1'b1; gemm_done_id = 6'h35; step(); gemm_done = 1'b0;
    chk("st_same_cycle", 64'(store_req), 64'(0));
    step();
    chk("st_rise", 64'({store_req, store_matrix, store_addr}), 64'({1'b1, 6'h35, 32'd100}));
    store_ack = 1'b1; step(); store_ack = 1'b0;
    chk("st_idle", 64'(idle), 64'(1));

    // Reset in the middle of ISSUE with three queued entries
    push({2'd1, 6'h02, 32'h0000_0020});
    wait_req(10, ok);
    chk("rst_mid_timeout", 64'(ok), 64'(1));
    push({2'd2, 6'h03, 32'h1});
    push({2'd2, 6'h04, 32'h2});
    push({2'd3, 6'h00, 32'h3});
    chk("rst_mid_queued", 64'({load_req, instrFIFO_empty}), 64'(2'b10));
    #2 nRST = 1'b0;
    #1;
    chk("rst_mid_outs", 64'({reqs(), load_matrix, load_addr}), 64'(0));
    chk("rst_mid_status", 64'({instrFIFO_empty, instrFIFO_full, idle}), 64'(3'b101));
    step();
    nRST = 1'b1;
    load_ack = 1'b1; load_done = 1'b1; load_done_id = 6'h02;
    step();
    load_ack = 1'b0; load_done = 1'b0;
    seen = 1'b0;
    repeat (5) begin step(); seen = seen | load_req | store_req | gemm_req; end
    chk("rst_post_noreq", 64'(seen), 64'(0));
    chk("rst_post_idle", 64'({instrFIFO_empty, idle}), 64'(2'b11));
    push({2'd3, 6'h00, 8'h00, 6'h10, 6'h11, 6'h12, 6'h13});
    step(); step();
    chk("rst_post_gemm", 64'({gemm_req, gemm_rd}), 64'({1'b1, 6'h10}));
    gemm_ack = 1'b1; step(); gemm_ack = 1'b0;
    gemm_done = 1'b1; gemm_done_id = 6'h10; step(); gemm_done = 1'b0;
    chk("final_idle", 64'(idle), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_dispatch.md
INSTR_DISPATCH -- requirements
Module: instr_dispatch

Interface
REQ-001 Parameter: FIFO_DEPTH, default 8 (power of two, 2..64), instruction FIFO entries.
REQ-002 Ports, clock and reset first:
- CLK  in  1  clock; all state updates on rising edge.
- nRST  in  1  asynchronous, active-low reset.
- instrFIFO_WEN  in  1  push strobe.
- instrFIFO_wdata  in  40  instruction:
  - opcode[39:38]: 0 NOP, 1 LOAD, 2 STORE, 3 GEMM.
  - ls_matrix_rd_gemm_new_weight[37:32]
  - ls_addr_gemm_gemm_sel[31:0]
- instrFIFO_full / instrFIFO_empty  out  1  FIFO status.
- load_req  out  1  /  load_ack  in  1  LOAD issue handshake.
- load_matrix  out  6  /  load_addr  out  32  LOAD payload.
- store_req  out  1  /  store_ack  in  1  STORE issue handshake.
- store_matrix  out  6  /  store_addr  out  32  STORE payload.
- gemm_req  out  1  /  gemm_ack  in  1  GEMM issue handshake.
- gemm_new_weight  out  1  GEMM weight-reload flag.
- gemm_rd, gemm_rs1, gemm_rs2, gemm_rs3  out  6 each  GEMM matrix IDs.
- load_done  in  1  /  load_done_id  in  6  LOAD completion.
- gemm_done  in  1  /  gemm_done_id  in  6  GEMM completion.
- idle  out  1  FIFO empty, FSM in IDLE, no matrix busy.

Function
REQ-003 Push occurs when instrFIFO_WEN=1 and full=0; a push while full is dropped and the FIFO is unchanged.
REQ-004 Push and pop in the same cycle are both accepted when not empty, including when full; the count is unchanged.
REQ-005 Read and write pointers wrap modulo FIFO_DEPTH; full and empty are registered status, exact at every occupancy.
REQ-006 The FSM has three states:
- IDLE: if not empty, pop head into the instruction register and go to CHECK.
- CHECK: evaluate hazards; when clear, assert the matching req and go to ISSUE.
- ISSUE: hold req and payload stable until ack=1; in the ack cycle drop req and go to IDLE.
REQ-007 NOP is popped and discarded in IDLE; no req is asserted.
REQ-008 Field decode:
- LOAD/STORE: matrix = field[5:0], addr = sel[31:0].
- GEMM: new_weight = field[5], rd = sel[23:18], rs1 = sel[17:12], rs2 = sel[11:6], rs3 = sel[5:0]; sel[31:24] is ignored.
REQ-009 Scoreboard is a 64-bit busy vector indexed by matrix ID.
- Set bit on ack of LOAD (load_matrix) or GEMM (gemm_rd).
- Clear bit on load_done (load_done_id) or gemm_done (gemm_done_id).
- Set and clear of the same ID in one cycle: set wins.
REQ-010 Hazard rule in CHECK:
- LOAD stalls while busy[matrix].
- STORE stalls while busy[matrix].
- GEMM stalls while any of busy[rs1], busy[rs2], busy[rs3], busy[rd] is set.
REQ-011 At most one req is high in any cycle; at most one instruction is in flight between pop and ack.
REQ-012 Minimum latency is 3 cycles, hazard-free: push at edge N, pop at N+1, CHECK at N+2, req visible after N+2.
REQ-013 An ack arriving while its req is low is ignored.
REQ-014 done with an ID whose busy bit is clear is ignored.

Reset
REQ-015 On nRST=0, asynchronously:
- FIFO pointers and count to 0.
- instrFIFO_empty=1, instrFIFO_full=0.
- FSM to IDLE, busy vector to 0.
- All req outputs 0, all payload outputs 0, idle=1.
REQ-016 Reset asserted during ISSUE discards the in-flight instruction and all queued entries; no req is asserted after release until a new push.

Configuration
REQ-017 Macro DISPATCH_SCOREBOARD_EN.
- Defined: per-ID hazard rule of REQ-010.
- Undefined: the busy vector is replaced by a 7-bit outstanding counter.
  - Counter increments on LOAD/GEMM ack and decrements on each done; simultaneous increment and decrement leaves it unchanged.
  - GEMM and STORE stall in CHECK until the counter is 0; LOAD never stalls.

Verification
REQ-018 Push LOAD {1,6'h25,32'h4}, ack 2 cycles after req -> load_req high 3 cycles after push, load_matrix=6'h25, load_addr=4, busy[0x25]=1.
REQ-019 Fill 8 entries, push a 9th with pops blocked -> full=1, 9th entry dropped; draining issues exactly 8 instructions in order.
REQ-020 Push LOAD 6'h15, then GEMM sel={8'b0,6'h35,6'h15,6'h25,6'h05}, with load_done withheld -> gemm_req stays 0; load_done_id=6'h15 -> gemm_req rises 1 cycle later with rd=6'h35, rs1=6'h15.
REQ-021 Push GEMM rd=6'h35, then STORE 6'h35 addr 100 -> store_req is held until gemm_done_id=6'h35, then store_addr=100.
REQ-022 Assert nRST mid-ISSUE with 3 entries queued -> all outputs reset immediately, empty=1, idle=1, no req after release.
REQ-023 Undefined-macro build, same stimulus as REQ-020 but rs IDs unrelated to the pending LOAD -> GEMM still stalls until the counter returns to 0.
